quote_order_gen: RTL and testbench
==================================

Name: quote_order_gen

Overview:
- Downstream consumer of the quote pricing stage.
- Takes the per-cycle bid/ask quote pair, compares it against the resting orders it believes are live, and emits a serialized stream of CANCEL/NEW order messages over a valid/ready handshake to the order-entry encoder.
- Tracks live order IDs per side, suppresses invalid or crossed quotes, and provides a level-sensitive kill switch that pulls all resting orders.

Parameters:
DATA_WIDTH, 32, integer price width (matches quote outputs)
QTY_WIDTH, 16, order quantity width
ID_WIDTH, 16, order ID width
DEFAULT_QTY, 100, quantity placed on every NEW
MIN_TICK_DELTA, 1, minimum absolute price change (integer ticks) that triggers a requote on a side

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_buy_price  in  DATA_WIDTH  quoted bid price
i_ask_price  in  DATA_WIDTH  quoted ask price
i_data_valid  in  1  quote pair valid this cycle
i_kill  in  1  level: cancel all live orders and block new ones
o_order_valid  out  1  order message valid
i_order_ready  in  1  downstream accepts message
o_order_type  out  2  2'b00 NEW, 2'b01 CANCEL
o_order_side  out  1  0 bid, 1 ask
o_order_price  out  DATA_WIDTH  price (NEW only; 0 for CANCEL)
o_order_qty  out  QTY_WIDTH  DEFAULT_QTY on NEW, 0 on CANCEL
o_order_id  out  ID_WIDTH  new ID (NEW) or ID being cancelled (CANCEL)
o_busy  out  1  FSM not in IDLE or pending quote held

Behaviour:
- Reset (async assert, sync release): all outputs 0, FSM IDLE, pending flag 0, bid/ask live flags 0, live prices/IDs 0, ID counter 0.
- Quote capture: on i_data_valid with buy!=0, ask!=0 and buy<ask (unsigned), latch pair into pending regs and set pending. Last-wins overwrite while busy. Crossed/zero/equal quotes are dropped silently. No capture while i_kill=1.
- IDLE decision (one cycle):
  - If i_kill and any side live: go to cancel path, targeting live sides only.
  - Else if pending:
    - side_change = !live || |pend - live_price| >= MIN_TICK_DELTA.
    - Clear pending, snapshot pend into working regs.
    - Visit needed states in order CANCEL_BID -> NEW_BID -> CANCEL_ASK -> NEW_ASK.
    - Skip CANCEL on a side that has no live order.
    - Skip both states on an unchanged side.
    - Neither side changed: stay IDLE.
- Capture and pending-clear in the same cycle: the new capture wins and pending stays 1.
- FSM states: IDLE, CANCEL_BID, NEW_BID, CANCEL_ASK, NEW_ASK. Each non-IDLE state drives o_order_valid=1 and advances only on the valid&&ready handshake.
- Output regs are registered. Message fields stay stable while valid && !ready. First message appears the cycle after the IDLE decision (latency 2 from i_data_valid to o_order_valid with ready high).
- Handshake effects:
  - CANCEL handshake clears that side's live flag.
  - NEW handshake increments the ID counter (issued ID = counter+1; wraps from 2^ID_WIDTH-1 to 1, 0 never issued), sets live flag, and stores price/ID.
- Kill:
  - i_kill rising mid-sequence: the current message completes. Remaining NEW states are skipped; CANCELs for live sides are still issued. Return to IDLE.
  - While i_kill=1, no NEW is ever issued and pending is cleared.
- Back-to-back: returning to IDLE with pending set starts the next decision the following cycle.

Decomposition:
- Shared package quote_pkg holds:
  - order_type_e enum (NEW=2'b00, CANCEL=2'b01)
  - side constants BID=0, ASK=1
  - order_msg_t packed struct {type, side, price, qty, id}
  - ogen_state_e enum
- One sub-module, order_id_alloc: counter with skip-zero wrap, increment strobe, current/next outputs.

Test Plan:
- Reset, i_order_ready=1, quote buy=100 ask=102 -> NEW bid 100 id 1, then NEW ask 102 id 2; no CANCELs; o_busy drops after.
- Live 100/102, quote 99/102 -> CANCEL bid id 1, NEW bid 99 id 3; ask untouched.
- Quote 100/100, then 0/105 -> no messages, o_busy stays 0.
- Live orders, i_order_ready=0 for 5 cycles during NEW_BID -> o_order_* stable all 5 cycles. Meanwhile quotes 97/103 then 96/104 -> after the current sequence, only 96/104 is requoted.
- Live 100/102, assert i_kill during NEW_BID stall -> that NEW completes, then CANCEL bid and CANCEL ask; no further NEWs while kill high. Deassert kill plus quote 100/102 -> fresh NEWs.
- Preload ID counter near wrap (force, or 2^ID_WIDTH-1 NEWs) -> issued ID sequence ...,65535,1; async reset mid-handshake -> o_order_valid 0 immediately, live flags cleared.

Source files
------------

// File: rtl/quote_pkg.sv
// rtl/quote_pkg.sv - shared types for the quote-to-order generator
package quote_pkg;

    localparam int PKG_DATA_W = 32;
    localparam int PKG_QTY_W  = 16;
    localparam int PKG_ID_W   = 16;

    typedef enum logic [1:0] {
        ORDER_NEW    = 2'b00,
        ORDER_CANCEL = 2'b01
    } order_type_e;

    localparam logic SIDE_BID = 1'b0;
    localparam logic SIDE_ASK = 1'b1;

    typedef struct packed {
        order_type_e             msg_type;
        logic                    side;
        logic [PKG_DATA_W-1:0]   price;
        logic [PKG_QTY_W-1:0]    qty;
        logic [PKG_ID_W-1:0]     id;
    } order_msg_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CANCEL_BID,
        ST_NEW_BID,
        ST_CANCEL_ASK,
        ST_NEW_ASK
    } ogen_state_e;

endpackage

// File: rtl/order_id_alloc.sv
// rtl/order_id_alloc.sv - order ID counter that wraps past zero
// Ports: i_clk, i_rst_n (async active-low), i_incr (consume one ID),
//        o_cur_id (last issued ID, 0 after reset), o_next_id (ID the next NEW gets)
module order_id_alloc #(
    parameter int ID_WIDTH = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_incr,
    output logic [ID_WIDTH-1:0] o_cur_id,
    output logic [ID_WIDTH-1:0] o_next_id
);

    logic [ID_WIDTH-1:0] cur_id;

    // ID 0 is reserved as "no order", so the wrap lands on 1
    assign o_next_id = (cur_id == '1) ? ID_WIDTH'(1) : cur_id + ID_WIDTH'(1);
    assign o_cur_id  = cur_id;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cur_id <= '0;
        end else if (i_incr) begin
            cur_id <= o_next_id;
        end
    end

endmodule

// File: rtl/quote_order_gen.sv
// rtl/quote_order_gen.sv - turns bid/ask quotes into serialized CANCEL/NEW order messages
// Ports: i_clk, i_rst_n (async active-low); i_buy_price/i_ask_price/i_data_valid quote input;
//        i_kill level kill switch; o_order_* message stream with o_order_valid/i_order_ready;
//        o_busy high while a sequence runs or a quote is pending
module quote_order_gen
    import quote_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int QTY_WIDTH      = 16,
    parameter int ID_WIDTH       = 16,
    parameter int DEFAULT_QTY    = 100,
    parameter int MIN_TICK_DELTA = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_buy_price,
    input  logic [DATA_WIDTH-1:0] i_ask_price,
    input  logic                  i_data_valid,
    input  logic                  i_kill,
    output logic                  o_order_valid,
    input  logic                  i_order_ready,
    output logic [1:0]            o_order_type,
    output logic                  o_order_side,
    output logic [DATA_WIDTH-1:0] o_order_price,
    output logic [QTY_WIDTH-1:0]  o_order_qty,
    output logic [ID_WIDTH-1:0]   o_order_id,
    output logic                  o_busy
);

    localparam logic [DATA_WIDTH-1:0] TICK = DATA_WIDTH'(MIN_TICK_DELTA);

    function automatic logic [DATA_WIDTH-1:0] abs_diff(input logic [DATA_WIDTH-1:0] a,
                                                       input logic [DATA_WIDTH-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    function automatic logic [ID_WIDTH-1:0] id_inc(input logic [ID_WIDTH-1:0] x);
        return (x == '1) ? ID_WIDTH'(1) : x + ID_WIDTH'(1);
    endfunction

    ogen_state_e state, nxt_state;

    logic                  pending;
    logic [DATA_WIDTH-1:0] pend_bid, pend_ask;
    logic                  bid_live, ask_live;
    logic [DATA_WIDTH-1:0] bid_live_price, ask_live_price;
    logic [ID_WIDTH-1:0]   bid_live_id, ask_live_id;

    // Per-sequence step mask: [0] CANCEL_BID, [1] NEW_BID, [2] CANCEL_ASK, [3] NEW_ASK
    logic [3:0]            work_do, dec_do, avail;
    logic [DATA_WIDTH-1:0] work_bid, work_ask;

    logic                  capture, hs, hs_new, bid_chg, ask_chg;
    logic [ID_WIDTH-1:0]   alloc_cur, alloc_next, new_id_n;

    logic [1:0]            type_n;
    logic                  side_n;
    logic [DATA_WIDTH-1:0] price_n;
    logic [QTY_WIDTH-1:0]  qty_n;
    logic [ID_WIDTH-1:0]   id_n;

    assign capture = i_data_valid && !i_kill && (i_buy_price != '0) && (i_ask_price != '0)
                     && (i_buy_price < i_ask_price);
    assign hs      = o_order_valid && i_order_ready;
    assign hs_new  = hs && ((state == ST_NEW_BID) || (state == ST_NEW_ASK));
    assign bid_chg = !bid_live || (abs_diff(pend_bid, bid_live_price) >= TICK);
    assign ask_chg = !ask_live || (abs_diff(pend_ask, ask_live_price) >= TICK);
    assign o_busy  = (state != ST_IDLE) || pending;

    // A NEW accepted this cycle already consumes alloc_next, so the following NEW skips past it
    assign new_id_n = id_inc(hs_new ? alloc_next : alloc_cur);

    order_id_alloc #(
        .ID_WIDTH (ID_WIDTH)
    ) u_id_alloc (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_incr    (hs_new),
        .o_cur_id  (alloc_cur),
        .o_next_id (alloc_next)
    );

    always_comb begin
        dec_do = 4'b0000;
        if (i_kill) begin
            dec_do = {1'b0, ask_live, 1'b0, bid_live};
        end else if (pending) begin
            dec_do = {ask_chg, ask_chg && ask_live, bid_chg, bid_chg && bid_live};
        end
    end

    always_comb begin
        avail = 4'b0000;
        case (state)
            ST_IDLE:       avail = dec_do;
            ST_CANCEL_BID: avail = work_do & 4'b1110;
            ST_NEW_BID:    avail = work_do & 4'b1100;
            ST_CANCEL_ASK: avail = work_do & 4'b1000;
            default:       avail = 4'b0000;
        endcase
    end

    always_comb begin
        nxt_state = state;
        if (state == ST_IDLE || (hs && !i_kill)) begin
            if (avail[0])      nxt_state = ST_CANCEL_BID;
            else if (avail[1]) nxt_state = ST_NEW_BID;
            else if (avail[2]) nxt_state = ST_CANCEL_ASK;
            else if (avail[3]) nxt_state = ST_NEW_ASK;
            else               nxt_state = ST_IDLE;
        end else if (hs) begin
            // Kill lands mid-sequence: finish here; IDLE then cancels whatever is live
            nxt_state = ST_IDLE;
        end
    end

    always_comb begin
        type_n  = ORDER_NEW;
        side_n  = SIDE_BID;
        price_n = '0;
        qty_n   = '0;
        id_n    = '0;
        case (nxt_state)
            ST_CANCEL_BID: begin
                type_n = ORDER_CANCEL;
                id_n   = bid_live_id;
            end
            ST_NEW_BID: begin
                price_n = (state == ST_IDLE) ? pend_bid : work_bid;
                qty_n   = QTY_WIDTH'(DEFAULT_QTY);
                id_n    = new_id_n;
            end
            ST_CANCEL_ASK: begin
                type_n = ORDER_CANCEL;
                side_n = SIDE_ASK;
                id_n   = ask_live_id;
            end
            ST_NEW_ASK: begin
                side_n  = SIDE_ASK;
                price_n = (state == ST_IDLE) ? pend_ask : work_ask;
                qty_n   = QTY_WIDTH'(DEFAULT_QTY);
                id_n    = new_id_n;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= nxt_state;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pending  <= 1'b0;
            pend_bid <= '0;
            pend_ask <= '0;
        end else if (capture) begin
            pending  <= 1'b1;
            pend_bid <= i_buy_price;
            pend_ask <= i_ask_price;
        end else if (i_kill || (state == ST_IDLE)) begin
            pending  <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            work_do  <= '0;
            work_bid <= '0;
            work_ask <= '0;
        end else if (state == ST_IDLE) begin
            work_do  <= dec_do;
            work_bid <= pend_bid;
            work_ask <= pend_ask;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bid_live       <= 1'b0;
            ask_live       <= 1'b0;
            bid_live_price <= '0;
            ask_live_price <= '0;
            bid_live_id    <= '0;
            ask_live_id    <= '0;
        end else if (hs) begin
            case (state)
                ST_CANCEL_BID: bid_live <= 1'b0;
                ST_NEW_BID: begin
                    bid_live       <= 1'b1;
                    bid_live_price <= o_order_price;
                    bid_live_id    <= o_order_id;
                end
                ST_CANCEL_ASK: ask_live <= 1'b0;
                ST_NEW_ASK: begin
                    ask_live       <= 1'b1;
                    ask_live_price <= o_order_price;
                    ask_live_id    <= o_order_id;
                end
                default: ;
            endcase
        end
    end

    // Fields only reload on a state entry or handshake, so a stalled message holds still
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_order_valid <= 1'b0;
            o_order_type  <= '0;
            o_order_side  <= 1'b0;
            o_order_price <= '0;
            o_order_qty   <= '0;
            o_order_id    <= '0;
        end else if ((state == ST_IDLE) || hs) begin
            o_order_valid <= (nxt_state != ST_IDLE);
            o_order_type  <= type_n;
            o_order_side  <= side_n;
            o_order_price <= price_n;
            o_order_qty   <= qty_n;
            o_order_id    <= id_n;
        end
    end

endmodule

// File: tb/tb_quote_order_gen.sv
// tb/tb_quote_order_gen.sv - scoreboard bench for quote_order_gen
module tb_quote_order_gen;
    import quote_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] buy_price, ask_price;
    logic        data_valid, kill, order_ready;
    logic        order_valid, order_side, busy;
    logic [1:0]  order_type;
    logic [31:0] order_price;
    logic [15:0] order_qty, order_id;

    int n_checks = 0;
    int n_pass   = 0;

    order_msg_t exp_q[$];

    always #5 clk = ~clk;

    quote_order_gen dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_buy_price   (buy_price),
        .i_ask_price   (ask_price),
        .i_data_valid  (data_valid),
        .i_kill        (kill),
        .o_order_valid (order_valid),
        .i_order_ready (order_ready),
        .o_order_type  (order_type),
        .o_order_side  (order_side),
        .o_order_price (order_price),
        .o_order_qty   (order_qty),
        .o_order_id    (order_id),
        .o_busy        (busy)
    );

    task automatic check_eq(input string tag, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    function automatic order_msg_t mk(input order_type_e t, input logic s,
                                      input logic [31:0] p, input logic [15:0] id);
        order_msg_t m;
        m.msg_type = t;
        m.side     = s;
        m.price    = (t == ORDER_NEW) ? p : 32'd0;
        m.qty      = (t == ORDER_NEW) ? 16'd100 : 16'd0;
        m.id       = id;
        return m;
    endfunction

    function automatic order_msg_t cur_msg();
        return order_msg_t'({order_type, order_side, order_price, order_qty, order_id});
    endfunction

    // Monitor: every accepted message is popped against the scoreboard
    always @(negedge clk) begin
        if (rst_n && order_valid && order_ready) begin
            check_eq("sb_avail", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check_eq("msg", cur_msg(), exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_quote(input logic [31:0] b, input logic [31:0] a);
        buy_price  = b;
        ask_price  = a;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) break;
        end
        check_eq({tag, "_drain"}, {exp_q.size() == 0, busy}, 2'b10);
        tick();
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (order_valid) break;
        end
        check_eq({tag, "_valid"}, order_valid, 1'b1);
    endtask

    // One-cycle ready pulse: exactly one handshake on the message currently shown
    task automatic pulse_ready();
        tick();
        order_ready = 1'b1;
        tick();
        order_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; buy_price = '0; ask_price = '0;
        data_valid = 1'b0; kill = 1'b0; order_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_valid", order_valid, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_fields", cur_msg(), 67'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // First quote: two NEWs, latency 2 from data_valid
        order_ready = 1'b1;
        exp_q.push_back(mk(ORDER_NEW, SIDE_BID, 100, 1));
        exp_q.push_back(mk(ORDER_NEW, SIDE_ASK, 102, 2));
        send_quote(100, 102);
        @(negedge clk);
        check_eq("lat1_valid", order_valid, 1'b0);
        check_eq("lat1_busy", busy, 1'b1);
        @(negedge clk);
        check_eq("lat2_valid", order_valid, 1'b1);
        drain("p1");

        // Bid moves, ask untouched
        exp_q.push_back(mk(ORDER_CANCEL, SIDE_BID, 0, 1));
        exp_q.push_back(mk(ORDER_NEW, SIDE_BID, 99, 3));
        send_quote(99, 102);
        drain("p2");

        // Equal and zero quotes are dropped
        send_quote(100, 100);
        send_quote(0, 105);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("bad_quote_busy", {order_valid, busy}, 2'b00);
        end
        tick();

        // Stall during NEW_BID with two quotes arriving; only the last one is requoted
        order_ready = 1'b0;
        exp_q.push_back(mk(ORDER_CANCEL, SIDE_BID, 0, 3));
        exp_q.push_back(mk(ORDER_NEW, SIDE_BID, 98, 4));
        send_quote(98, 102);
        wait_valid("p4_cb");
        check_eq("p4_cb_type", order_type, ORDER_CANCEL);
        pulse_ready();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("stall_stable", cur_msg(), mk(ORDER_NEW, SIDE_BID, 98, 4));
            tick();
            data_valid = (i == 0) || (i == 2);
            buy_price  = (i == 0) ? 32'd97 : 32'd96;
            ask_price  = (i == 0) ? 32'd103 : 32'd104;
            if (i == 2) begin
                exp_q.push_back(mk(ORDER_CANCEL, SIDE_BID, 0, 4));
                exp_q.push_back(mk(ORDER_NEW, SIDE_BID, 96, 5));
                exp_q.push_back(mk(ORDER_CANCEL, SIDE_ASK, 0, 2));
                exp_q.push_back(mk(ORDER_NEW, SIDE_ASK, 104, 6));
            end
        end
        data_valid  = 1'b0;
        order_ready = 1'b1;
        drain("p4");

        // Kill during a stalled NEW_BID
        order_ready = 1'b0;
        exp_q.push_back(mk(ORDER_CANCEL, SIDE_BID, 0, 5));
        exp_q.push_back(mk(ORDER_NEW, SIDE_BID, 100, 7));
        send_quote(100, 102);
        wait_valid("p5_cb");
        pulse_ready();
        @(negedge clk);
        check_eq("p5_nb", cur_msg(), mk(ORDER_NEW, SIDE_BID, 100, 7));
        tick();
        kill = 1'b1;
        exp_q.push_back(mk(ORDER_CANCEL, SIDE_BID, 0, 7));
        exp_q.push_back(mk(ORDER_CANCEL, SIDE_ASK, 0, 6));
        tick();
        order_ready = 1'b1;
        send_quote(90, 95);
        drain("p5_kill");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("kill_quiet", {order_valid, busy}, 2'b00);
        end
        tick();
        kill = 1'b0;
        exp_q.push_back(mk(ORDER_NEW, SIDE_BID, 100, 8));
        exp_q.push_back(mk(ORDER_NEW, SIDE_ASK, 102, 9));
        send_quote(100, 102);
        drain("p5_resume");

        // ID wrap: 65534, 65535, then 1, 2
        force dut.u_id_alloc.cur_id = 16'hFFFD;
        tick();
        release dut.u_id_alloc.cur_id;
        exp_q.push_back(mk(ORDER_CANCEL, SIDE_BID, 0, 8));
        exp_q.push_back(mk(ORDER_NEW, SIDE_BID, 101, 16'hFFFE));
        exp_q.push_back(mk(ORDER_CANCEL, SIDE_ASK, 0, 9));
        exp_q.push_back(mk(ORDER_NEW, SIDE_ASK, 103, 16'hFFFF));
        send_quote(101, 103);
        drain("p6a");
        exp_q.push_back(mk(ORDER_CANCEL, SIDE_BID, 0, 16'hFFFE));
        exp_q.push_back(mk(ORDER_NEW, SIDE_BID, 102, 1));
        exp_q.push_back(mk(ORDER_CANCEL, SIDE_ASK, 0, 16'hFFFF));
        exp_q.push_back(mk(ORDER_NEW, SIDE_ASK, 104, 2));
        send_quote(102, 104);
        drain("p6b");

        // Async reset while a CANCEL is stalled
        order_ready = 1'b0;
        send_quote(110, 112);
        wait_valid("p7");
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_valid", order_valid, 1'b0);
        check_eq("async_rst_busy", busy, 1'b0);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        order_ready = 1'b1;
        exp_q.push_back(mk(ORDER_NEW, SIDE_BID, 100, 1));
        exp_q.push_back(mk(ORDER_NEW, SIDE_ASK, 102, 2));
        send_quote(100, 102);
        drain("p7");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
